grid_pixel_renderer: RTL and testbench

Parametrised tile-map renderer between VGA_DRIVER's pixel coordinates and its PIXEL_COLOR_IN. It holds a writable ROWS x COLS grid of STATE_W-bit cell states and maps each state through a palette to 8-bit RRRGGGBB. It can draw cell border lines and blink one highlighted cell (the robot position). A host-side write port with a valid/ready handshake and a full-grid clear sequence replaces hard-coded grid assignments.

---
 rtl/grid_pixel_renderer.sv | 186 ++++++++++++++++++
 tb/tb_grid_pixel_renderer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_pixel_renderer.sv
// Tile-map pixel renderer: a ROWS x COLS grid of cell states mapped through a palette,
// with optional cell borders, a blinking highlighted cell, a host write port and a full-grid clear.
module grid_pixel_renderer #(
    parameter int          ROWS         = 4,
    parameter int          COLS         = 5,
    parameter int          CELL_PX      = 50,
    parameter int          COORD_W      = 10,
    parameter int          STATE_W      = 2,
    parameter logic [63:0] PALETTE      = {8'h00, 8'h00, 8'h00, 8'h00, 8'hE0, 8'h1C, 8'h03, 8'h00},
    parameter logic [7:0]  BG_COLOR     = 8'h00,
    parameter logic [7:0]  LINE_COLOR   = 8'hFF,
    parameter int          BLINK_CYCLES = 12500000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [COORD_W-1:0] i_pixel_x,
    input  logic [COORD_W-1:0] i_pixel_y,
    output logic [7:0]         o_pixel_color,
    input  logic               i_lines_en,
    input  logic               i_hl_en,
    input  logic [3:0]         i_hl_row,
    input  logic [3:0]         i_hl_col,
    input  logic               i_wr_valid,
    output logic               o_wr_ready,
    input  logic [3:0]         i_wr_row,
    input  logic [3:0]         i_wr_col,
    input  logic [STATE_W-1:0] i_wr_data,
    output logic               o_wr_err,
    input  logic               i_clear_req,
    output logic               o_clear_done
);

    localparam int CELLS   = ROWS * COLS;
    localparam int IDX_W   = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(CELLS - 1);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]         r_fsm;
    logic [IDX_W-1:0]   r_clr_idx;
    logic               r_wr_ready;
    logic               r_wr_err;
    logic               r_clear_done;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink;

    logic               w_wr_fire;
    logic               w_wr_in_range;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [CELLS*STATE_W-1:0] w_cells;

    assign w_wr_fire     = i_wr_valid & r_wr_ready;
    assign w_wr_in_range = ({1'b0, i_wr_row} < 5'(ROWS)) && ({1'b0, i_wr_col} < 5'(COLS));
    assign w_wr_idx      = IDX_W'(i_wr_row * COLS + i_wr_col);

    // WR_READY is registered from the next state so it is high exactly while idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fsm        <= S_IDLE;
            r_clr_idx    <= '0;
            r_wr_ready   <= 1'b0;
            r_clear_done <= 1'b0;
            r_wr_err     <= 1'b0;
        end else begin
            r_clear_done <= 1'b0;
            r_wr_err     <= w_wr_fire & ~w_wr_in_range;
            case (r_fsm)
                S_IDLE: begin
                    r_wr_ready <= ~i_clear_req;
                    if (i_clear_req) begin
                        r_fsm     <= S_CLEAR;
                        r_clr_idx <= '0;
                    end
                end
                S_CLEAR: begin
                    if (r_clr_idx == LAST_IDX) begin
                        r_fsm        <= S_IDLE;
                        r_wr_ready   <= 1'b1;
                        r_clear_done <= 1'b1;
                    end else begin
                        r_clr_idx <= r_clr_idx + 1'b1;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CELLS; gi++) begin : g_cell
            logic [STATE_W-1:0] r_cell;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_cell <= '0;
                end else if (r_fsm == S_CLEAR && r_clr_idx == IDX_W'(gi)) begin
                    r_cell <= '0;
                end else if (w_wr_fire && w_wr_in_range && w_wr_idx == IDX_W'(gi)) begin
                    r_cell <= i_wr_data;
                end
            end
            assign w_cells[gi*STATE_W +: STATE_W] = r_cell;
        end
    endgenerate

    // Stage 1: coordinate to cell decode; divides are by a constant.
    logic [COORD_W-1:0] w_col;
    logic [COORD_W-1:0] w_row;
    logic               w_on_line;
    logic               w_in_grid;
    logic [IDX_W-1:0]   w_rd_idx;
    logic [STATE_W-1:0] w_rd_state;

    assign w_col      = COORD_W'(i_pixel_x / CELL_PX);
    assign w_row      = COORD_W'(i_pixel_y / CELL_PX);
    assign w_on_line  = ((i_pixel_x % CELL_PX) == 0) || ((i_pixel_y % CELL_PX) == 0);
    assign w_in_grid  = (w_row < COORD_W'(ROWS)) && (w_col < COORD_W'(COLS));
    assign w_rd_idx   = w_in_grid ? IDX_W'(w_row * COLS + w_col) : '0;
    assign w_rd_state = w_cells[w_rd_idx*STATE_W +: STATE_W];

    logic [3:0]         r_s1_row;
    logic [3:0]         r_s1_col;
    logic               r_s1_line;
    logic               r_s1_in_grid;
    logic [STATE_W-1:0] r_s1_state;
    logic [7:0]         r_color;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_row     <= '0;
            r_s1_col     <= '0;
            r_s1_line    <= 1'b0;
            r_s1_in_grid <= 1'b0;
            r_s1_state   <= '0;
        end else begin
            r_s1_row     <= w_row[3:0];
            r_s1_col     <= w_col[3:0];
            r_s1_line    <= w_on_line;
            r_s1_in_grid <= w_in_grid;
            r_s1_state   <= w_rd_state;
        end
    end

    // Stage 2: colour priority.
    logic [7:0] w_palette;
    logic       w_hl_hit;
    logic [7:0] w_color_next;

    assign w_palette = PALETTE[8*r_s1_state +: 8];
    assign w_hl_hit  = i_hl_en && (r_s1_row == i_hl_row) && (r_s1_col == i_hl_col) && r_blink;

    always_comb begin
        w_color_next = w_palette;
        if (!r_s1_in_grid) begin
            w_color_next = BG_COLOR;
        end else if (i_lines_en && r_s1_line) begin
            w_color_next = LINE_COLOR;
        end else if (w_hl_hit) begin
            w_color_next = ~w_palette;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_color     <= 8'h00;
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else begin
            r_color <= w_color_next;
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_blink     <= ~r_blink;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign o_pixel_color = r_color;
    assign o_wr_ready    = r_wr_ready;
    assign o_wr_err      = r_wr_err;
    assign o_clear_done  = r_clear_done;

endmodule

// File: tb/tb_grid_pixel_renderer.sv
// Directed testbench for grid_pixel_renderer: reset, rendering, write errors,
// blinking highlight, read/write collision, grid clear and reset during clear.
module tb_grid_pixel_renderer;

    localparam int ROWS = 4;
    localparam int COLS = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] px = '0;
    logic [9:0] py = '0;
    logic [7:0] color;
    logic       lines_en = 1'b0;
    logic       hl_en = 1'b0;
    logic [3:0] hl_row = '0;
    logic [3:0] hl_col = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [3:0] wr_row = '0;
    logic [3:0] wr_col = '0;
    logic [1:0] wr_data = '0;
    logic       wr_err;
    logic       clear_req = 1'b0;
    logic       clear_done;

    int checks = 0;
    int errors = 0;

    logic [1:0] model [ROWS][COLS];
    logic [7:0] pal [4] = '{8'h00, 8'h03, 8'h1C, 8'hE0};

    grid_pixel_renderer #(.BLINK_CYCLES(4)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_pixel_x     (px),
        .i_pixel_y     (py),
        .o_pixel_color (color),
        .i_lines_en    (lines_en),
        .i_hl_en       (hl_en),
        .i_hl_row      (hl_row),
        .i_hl_col      (hl_col),
        .i_wr_valid    (wr_valid),
        .o_wr_ready    (wr_ready),
        .i_wr_row      (wr_row),
        .i_wr_col      (wr_col),
        .i_wr_data     (wr_data),
        .o_wr_err      (wr_err),
        .i_clear_req   (clear_req),
        .o_clear_done  (clear_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic render(input int x, input int y, output logic [7:0] c);
        px = x[9:0];
        py = y[9:0];
        step();
        step();
        c = color;
        $display("render (%0d,%0d) -> %02h", x, y, c);
    endtask

    task automatic do_write(input int r, input int c, input int d);
        int n;
        wr_valid = 1'b1;
        wr_row   = r[3:0];
        wr_col   = c[3:0];
        wr_data  = d[1:0];
        n = 0;
        while (!wr_ready && n < 100) begin
            step();
            n++;
        end
        if (!wr_ready) begin
            checks++;
            errors++;
            $display("FAIL write_timeout: wr_ready=%0b required 1", wr_ready);
        end
        step();
        wr_valid = 1'b0;
        if (r < ROWS && c < COLS) model[r][c] = d[1:0];
        $display("write (%0d,%0d)=%0d", r, c, d);
    endtask

    task automatic test_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                model[r][c] = 2'd0;
        lines_en = 1'b1;
        px = 10'd0;
        py = 10'd0;
        step();
        step();
        checks++;
        if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b required 0", wr_ready); end
        checks++;
        if (color !== 8'h00) begin errors++; $display("FAIL reset_color: got %02h required 00", color); end
        checks++;
        if (wr_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b required 0", wr_err); end
        checks++;
        if (clear_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b required 0", clear_done); end
        rst_n = 1'b1;
        step();
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release: got %0b required 1", wr_ready); end
        step();
        checks++;
        if (color !== 8'hFF) begin errors++; $display("FAIL origin_line: got %02h required FF", color); end
        $display("test_reset done");
    endtask

    task automatic test_write_render();
        logic [7:0] c;
        lines_en = 1'b0;
        do_write(1, 2, 2);
        render(110, 60, c);
        checks++;
        if (c !== 8'h1C) begin errors++; $display("FAIL cell_1_2: got %02h required 1C", c); end
        render(260, 60, c);
        checks++;
        if (c !== 8'h00) begin errors++; $display("FAIL col5_bg: got %02h required 00", c); end
        render(10, 200, c);
        checks++;
        if (c !== 8'h00) begin errors++; $display("FAIL row4_bg: got %02h required 00", c); end
        do_write(3, 4, 3);
        render(249, 199, c);
        checks++;
        if (c !== 8'hE0) begin errors++; $display("FAIL last_cell_edge: got %02h required E0", c); end
        lines_en = 1'b1;
        render(100, 60, c);
        checks++;
        if (c !== 8'hFF) begin errors++; $display("FAIL vline: got %02h required FF", c); end
        render(110, 60, c);
        checks++;
        if (c !== 8'h1C) begin errors++; $display("FAIL off_line: got %02h required 1C", c); end
        render(250, 10, c);
        checks++;
        if (c !== 8'h00) begin errors++; $display("FAIL bg_over_line: got %02h required 00", c); end
        lines_en = 1'b0;
    endtask

    task automatic test_wr_err();
        logic [7:0] c;
        do_write(4, 0, 3);
        checks++;
        if (wr_err !== 1'b1) begin errors++; $display("FAIL err_pulse_row: got %0b required 1", wr_err); end
        step();
        checks++;
        if (wr_err !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %0b required 0", wr_err); end
        do_write(0, 5, 1);
        checks++;
        if (wr_err !== 1'b1) begin errors++; $display("FAIL err_pulse_col: got %0b required 1", wr_err); end
        do_write(0, 0, 0);
        checks++;
        if (wr_err !== 1'b0) begin errors++; $display("FAIL err_valid_write: got %0b required 0", wr_err); end
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < COLS; k++) begin
                render(k*50 + 25, r*50 + 25, c);
                checks++;
                if (c !== pal[model[r][k]]) begin
                    errors++;
                    $display("FAIL err_cells(%0d,%0d): got %02h required %02h", r, k, c, pal[model[r][k]]);
                end
            end
        end
    endtask

    task automatic test_collision();
        px = 10'd60;
        py = 10'd110;
        wr_valid = 1'b1;
        wr_row = 4'd2;
        wr_col = 4'd1;
        wr_data = 2'd3;
        step();
        wr_valid = 1'b0;
        model[2][1] = 2'd3;
        step();
        checks++;
        if (color !== 8'h00) begin errors++; $display("FAIL collision_old: got %02h required 00", color); end
        step();
        checks++;
        if (color !== 8'hE0) begin errors++; $display("FAIL collision_new: got %02h required E0", color); end
        $display("test_collision done");
    endtask

    task automatic test_blink();
        logic [7:0] s [24];
        int k;
        do_write(0, 0, 1);
        lines_en = 1'b0;
        hl_row = 4'd0;
        hl_col = 4'd0;
        hl_en = 1'b1;
        px = 10'd25;
        py = 10'd25;
        step();
        step();
        for (int i = 0; i < 24; i++) begin
            step();
            s[i] = color;
            $display("blink sample %0d -> %02h", i, s[i]);
        end
        k = 0;
        for (int i = 1; i < 24; i++) begin
            if (k == 0 && s[i] !== s[i-1]) k = i;
        end
        checks++;
        if (k == 0 || k > 4) begin errors++; $display("FAIL blink_first_toggle: got index %0d required 1..4", k); end
        if (k == 0) k = 1;
        checks++;
        if (s[k-1] !== 8'h03 && s[k-1] !== 8'hFC) begin
            errors++;
            $display("FAIL blink_colour: got %02h required 03 or FC", s[k-1]);
        end
        for (int j = k; j < 24; j++) begin
            logic [7:0] exp;
            exp = (((j - k) / 4) % 2 == 0) ? ~s[k-1] : s[k-1];
            checks++;
            if (s[j] !== exp) begin errors++; $display("FAIL blink_sample_%0d: got %02h required %02h", j, s[j], exp); end
        end
        hl_en = 1'b0;
        step();
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (color !== 8'h03) begin errors++; $display("FAIL no_highlight_%0d: got %02h required 03", i, color); end
        end
    endtask

    task automatic test_clear();
        logic [7:0] c;
        logic exp_last;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++)
                do_write(r, k, 3);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        checks++;
        if (wr_ready !== 1'b0) begin errors++; $display("FAIL clear_ready_drop: got %0b required 0", wr_ready); end
        wr_valid = 1'b1;
        wr_row = 4'd0;
        wr_col = 4'd0;
        wr_data = 2'd2;
        for (int n = 1; n <= 20; n++) begin
            if (n == 5) clear_req = 1'b1;
            step();
            clear_req = 1'b0;
            exp_last = (n == 20);
            $display("clear cycle %0d ready=%0b done=%0b", n, wr_ready, clear_done);
            checks++;
            if (wr_ready !== exp_last) begin errors++; $display("FAIL clear_ready_%0d: got %0b required %0b", n, wr_ready, exp_last); end
            checks++;
            if (clear_done !== exp_last) begin errors++; $display("FAIL clear_done_%0d: got %0b required %0b", n, clear_done, exp_last); end
        end
        step();
        wr_valid = 1'b0;
        checks++;
        if (clear_done !== 1'b0) begin errors++; $display("FAIL clear_done_width: got %0b required 0", clear_done); end
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++)
                model[r][k] = 2'd0;
        model[0][0] = 2'd2;
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < COLS; k++) begin
                render(k*50 + 25, r*50 + 25, c);
                checks++;
                if (c !== pal[model[r][k]]) begin
                    errors++;
                    $display("FAIL cleared(%0d,%0d): got %02h required %02h", r, k, c, pal[model[r][k]]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [7:0] c;
        logic seen_done;
        do_write(2, 3, 1);
        px = 10'd175;
        py = 10'd125;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int n = 0; n < 7; n++) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin errors++; $display("FAIL midclr_ready: got %0b required 0", wr_ready); end
        checks++;
        if (color !== 8'h00) begin errors++; $display("FAIL midclr_color: got %02h required 00", color); end
        checks++;
        if (clear_done !== 1'b0) begin errors++; $display("FAIL midclr_done: got %0b required 0", clear_done); end
        checks++;
        if (wr_err !== 1'b0) begin errors++; $display("FAIL midclr_err: got %0b required 0", wr_err); end
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL midclr_ready_after: got %0b required 1", wr_ready); end
        seen_done = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (clear_done) seen_done = 1'b1;
            step();
        end
        checks++;
        if (seen_done !== 1'b0) begin errors++; $display("FAIL midclr_no_done: got %0b required 0", seen_done); end
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < COLS; k++) begin
                model[r][k] = 2'd0;
                render(k*50 + 25, r*50 + 25, c);
                checks++;
                if (c !== 8'h00) begin
                    errors++;
                    $display("FAIL midclr_cell(%0d,%0d): got %02h required 00", r, k, c);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_render();
        test_wr_err();
        test_collision();
        test_blink();
        test_clear();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
